// File: rtl/tdc_timestamp_encoder_pkg.sv
// Shared widths, FSM state encoding and popcount helper
// for the TDC timestamp encoder.
package tdc_pkg;

    localparam int TAPS       = 4;
    localparam int COARSE_W   = 12;
    localparam int FINE_W     = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TS_W       = COARSE_W + FINE_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_BUSY    = 2'd2
    } tdc_state_e;

    // Counting every set bit makes the fine code tolerant of bubbles.
    function automatic logic [FINE_W-1:0] f_popcount(input logic [7:0] i_v);
        logic [FINE_W:0] v_sum;
        v_sum = '0;
        for (int i = 0; i < 8; i++) begin
            v_sum = v_sum + {{FINE_W{1'b0}}, i_v[i]};
        end
        return v_sum[FINE_W-1:0];
    endfunction

endpackage

// File: rtl/tdc_timestamp_encoder_if.sv
// Timestamp stream handshake between the encoder and its consumer.
// The encoder drives data/valid, and the consumer drives ready.
interface tdc_ts_if #(
    parameter int W = tdc_pkg::TS_W
) ();

    logic [W-1:0] TS_DATA;
    logic         TS_VALID;
    logic         TS_READY;

    modport master (
        output TS_DATA,
        output TS_VALID,
        input  TS_READY
    );

    modport slave (
        input  TS_DATA,
        input  TS_VALID,
        output TS_READY
    );

endinterface

// File: rtl/tdc_timestamp_encoder_fifo.sv
// First-word-fall-through timestamp buffer with a sticky overflow flag.
// When the buffer is full, a push is accepted only if a pop happens in the same cycle.
module tdc_ts_fifo
    import tdc_pkg::*;
#(
    parameter int WIDTH = TS_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf;

    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_full     = (r_count == L_FULL);
    assign o_valid    = (r_count != '0);
    assign w_pop      = o_valid & i_ready;
    assign w_wr       = i_push & (~w_full | w_pop);
    assign o_data     = o_valid ? r_mem[r_rptr] : '0;
    assign o_overflow = r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdc_timestamp_encoder.sv
// Thermometer-code TDC front end: synchronizes the tap inputs, captures coarse/fine
// timestamps, enforces dead time, and buffers the timestamps for a ready/valid consumer.
module tdc_timestamp_encoder #(
    parameter int TAPS       = tdc_pkg::TAPS,
    parameter int COARSE_W   = tdc_pkg::COARSE_W,
    parameter int FIFO_DEPTH = tdc_pkg::FIFO_DEPTH
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [TAPS-1:0] Z,
    tdc_ts_if.master        ts,
    output logic            OVERFLOW
);

    import tdc_pkg::FINE_W;
    import tdc_pkg::tdc_state_e;
    import tdc_pkg::ST_IDLE;
    import tdc_pkg::ST_CAPTURE;
    import tdc_pkg::ST_BUSY;
    import tdc_pkg::f_popcount;

    localparam int TS_W = COARSE_W + FINE_W;

    logic [TAPS-1:0]     r_zs1;
    logic [TAPS-1:0]     r_zs2;
    logic [COARSE_W-1:0] r_cnt;
    logic [COARSE_W-1:0] r_coarse;
    logic [FINE_W-1:0]   r_fine;
    tdc_state_e          r_state;

    tdc_state_e      w_state_nxt;
    logic            w_zs2_nz;
    logic            w_push;
    logic [7:0]      w_zs2_ext;
    logic [FINE_W-1:0] w_fine;
    logic [TS_W-1:0] w_ts;
    logic [TS_W-1:0] w_rd_data;
    logic            w_rd_valid;
    logic            w_ovf;

    assign w_zs2_nz  = |r_zs2;
    assign w_zs2_ext = 8'(r_zs2);
    assign w_fine    = f_popcount(w_zs2_ext);
    assign w_ts      = {r_coarse, r_fine};

    // Z is asynchronous to CLK, so only r_zs2 is used downstream.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_zs1 <= '0;
            r_zs2 <= '0;
        end else begin
            r_zs1 <= Z;
            r_zs2 <= r_zs1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + COARSE_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_coarse <= '0;
            r_fine   <= '0;
        end else if (r_state == ST_IDLE && w_zs2_nz) begin
            r_coarse <= r_cnt;
            r_fine   <= w_fine;
        end
    end

    // A capture is followed by BUSY until the line clears, which gives the dead time.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_zs2_nz) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_push      = 1'b1;
                w_state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (!w_zs2_nz) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    tdc_ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst_n    (RST_N),
        .i_push     (w_push),
        .i_data     (w_ts),
        .i_ready    (ts.TS_READY),
        .o_data     (w_rd_data),
        .o_valid    (w_rd_valid),
        .o_overflow (w_ovf)
    );

    assign ts.TS_DATA  = w_rd_data;
    assign ts.TS_VALID = w_rd_valid;
    assign OVERFLOW    = w_ovf;

endmodule

// File: tb/tb_tdc_timestamp_encoder.sv
// Directed scoreboard bench for tdc_timestamp_encoder.
module tb_tdc_timestamp_encoder;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] Z;
    logic       OVERFLOW;

    tdc_ts_if ts_if ();

    tdc_timestamp_encoder #(
        .TAPS       (4),
        .COARSE_W   (12),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Z        (Z),
        .ts       (ts_if),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    int          n_pop = 0;
    int          tcnt  = 0;
    logic [14:0] q[$];
    logic [14:0] e;

    function automatic logic [14:0] exp_ts(input int c, input logic [3:0] z);
        logic [11:0] v_c;
        logic [2:0]  v_f;
        v_c = 12'(c % 4096);
        v_f = 3'($countones(z));
        return {v_c, v_f};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake decided at the negedge, where the inputs for the next edge are final.
    task automatic cyc();
        @(negedge CLK);
        if (RST_N && ts_if.TS_VALID && ts_if.TS_READY) begin
            n_pop++;
            n_chk++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL pop_unexpected: observed %0h expected none", ts_if.TS_DATA);
            end
            if (q.size() != 0) begin
                chk("pop_data", 32'(ts_if.TS_DATA), 32'(q.pop_front()));
            end
        end
        @(posedge CLK);
        #1;
        tcnt++;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        Z     = '0;
        q.delete();
        repeat (3) cyc();
        RST_N = 1'b1;
        tcnt  = 0;
    endtask

    task automatic ev(input logic [3:0] z, input bit exp_push);
        Z = z;
        if (exp_push) begin
            q.push_back(exp_ts(tcnt + 2, z));
        end
        repeat (2) cyc();
        Z = '0;
        repeat (5) cyc();
    endtask

    initial begin
        ts_if.TS_READY = 1'b1;
        RST_N          = 1'b0;
        Z              = '0;
        do_reset();
        chk("rst_valid", 32'(ts_if.TS_VALID), 0);
        chk("rst_data", 32'(ts_if.TS_DATA), 0);
        chk("rst_ovf", 32'(OVERFLOW), 0);
        chk("rst_cnt", 32'(dut.r_cnt), 0);

        repeat (20) cyc();
        chk("idle_cnt20", 32'(dut.r_cnt), 20);
        chk("idle_valid", 32'(ts_if.TS_VALID), 0);
        chk("idle_ovf", 32'(OVERFLOW), 0);

        while (tcnt < 100) cyc();
        Z = 4'b0111;
        e = exp_ts(tcnt + 2, Z);
        q.push_back(e);
        repeat (3) cyc();
        Z = '0;
        chk("lat_103_low", 32'(ts_if.TS_VALID), 0);
        cyc();
        chk("lat_104_high", 32'(ts_if.TS_VALID), 1);
        chk("lat_104_data", 32'(ts_if.TS_DATA), 32'(e));
        cyc();
        chk("pulse_105_low", 32'(ts_if.TS_VALID), 0);
        chk("pops_a", 32'(n_pop), 1);

        Z = 4'b1011;
        q.push_back(exp_ts(tcnt + 2, Z));
        repeat (10) cyc();
        Z = '0;
        repeat (8) cyc();
        chk("dead_time_pops", 32'(n_pop), 2);
        chk("dead_time_q", 32'(q.size()), 0);

        ts_if.TS_READY = 1'b0;
        ev(4'b0001, 1'b1);
        ev(4'b0011, 1'b1);
        ev(4'b0111, 1'b1);
        ev(4'b1111, 1'b1);
        chk("full_count", 32'(dut.u_fifo.r_count), 4);
        chk("full_head", 32'(ts_if.TS_DATA), 32'(q[0]));
        Z = 4'b0101;
        q.push_back(exp_ts(tcnt + 2, Z));
        repeat (2) cyc();
        Z = '0;
        cyc();
        ts_if.TS_READY = 1'b1;
        cyc();
        ts_if.TS_READY = 1'b0;
        repeat (3) cyc();
        chk("coinc_ovf", 32'(OVERFLOW), 0);
        chk("coinc_count", 32'(dut.u_fifo.r_count), 4);
        chk("coinc_pops", 32'(n_pop), 3);
        ts_if.TS_READY = 1'b1;
        repeat (6) cyc();
        chk("coinc_drain_valid", 32'(ts_if.TS_VALID), 0);
        chk("coinc_drain_q", 32'(q.size()), 0);
        chk("coinc_drain_pops", 32'(n_pop), 7);

        ts_if.TS_READY = 1'b0;
        ev(4'b0001, 1'b1);
        ev(4'b1100, 1'b1);
        ev(4'b1110, 1'b1);
        ev(4'b1111, 1'b1);
        chk("ovf_before", 32'(OVERFLOW), 0);
        ev(4'b0101, 1'b0);
        chk("ovf_after", 32'(OVERFLOW), 1);
        chk("ovf_head", 32'(ts_if.TS_DATA), 32'(q[0]));
        chk("ovf_count", 32'(dut.u_fifo.r_count), 4);
        ts_if.TS_READY = 1'b1;
        repeat (6) cyc();
        chk("ovf_drain_valid", 32'(ts_if.TS_VALID), 0);
        chk("ovf_drain_q", 32'(q.size()), 0);
        chk("ovf_drain_pops", 32'(n_pop), 11);
        chk("ovf_sticky", 32'(OVERFLOW), 1);

        do_reset();
        chk("ovf_cleared", 32'(OVERFLOW), 0);
        chk("rst2_valid", 32'(ts_if.TS_VALID), 0);

        while (tcnt < 4095) cyc();
        Z = 4'b1111;
        q.push_back(exp_ts(tcnt + 2, Z));
        repeat (3) cyc();
        Z = '0;
        cyc();
        chk("wrap_valid", 32'(ts_if.TS_VALID), 1);
        chk("wrap_coarse", 32'(ts_if.TS_DATA[14:3]), 1);
        repeat (4) cyc();
        chk("wrap_pops", 32'(n_pop), 12);

        ts_if.TS_READY = 1'b0;
        ev(4'b0011, 1'b1);
        Z = 4'b1111;
        repeat (6) cyc();
        chk("busy_state", 32'(dut.r_state), 2);
        chk("busy_count", 32'(dut.u_fifo.r_count), 2);
        do_reset();
        chk("busy_rst_valid", 32'(ts_if.TS_VALID), 0);
        chk("busy_rst_count", 32'(dut.u_fifo.r_count), 0);
        ts_if.TS_READY = 1'b1;
        repeat (3) cyc();
        ev(4'b0111, 1'b1);
        chk("post_rst_pops", 32'(n_pop), 13);
        chk("final_q", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
